// File: rtl/lcd_mem_reader_if.sv
// Memory command bus and byte-stream handshake between lcd_mem_reader and its neighbours.
// master = the reader; slave = the memory / downstream side.
interface lcd_mem_reader_if #(
   parameter int ADDR_W = 5,
   parameter int DATA_W = 8
);
   logic [1:0]        mem_rw;
   logic [ADDR_W-1:0] mem_addr;
   logic [DATA_W-1:0] mem_save;
   logic [DATA_W-1:0] out_data;
   logic [ADDR_W-1:0] out_index;
   logic              out_valid;
   logic              out_ready;

   modport master (
      output mem_rw,
      output mem_addr,
      input  mem_save,
      output out_data,
      output out_index,
      output out_valid,
      input  out_ready
   );

   modport slave (
      input  mem_rw,
      input  mem_addr,
      output mem_save,
      input  out_data,
      input  out_index,
      input  out_valid,
      output out_ready
   );
endinterface

// File: rtl/lcd_mem_reader.sv
// Streams a run of bytes out of the 16x8 character memory onto a valid/ready handshake.
// Optional REFRESH_LOOP_EN: adds a stop input and repeats the run until stopped.
module lcd_mem_reader #(
   parameter int DEPTH  = 16,
   parameter int ADDR_W = 5,
   parameter int DATA_W = 8
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              start,
   input  logic [ADDR_W-1:0] base_addr,
   input  logic [ADDR_W-1:0] len,
`ifdef REFRESH_LOOP_EN
   input  logic              stop,
`endif
   output logic              busy,
   output logic              done,
   lcd_mem_reader_if.master  bus
);

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_REQ  = 2'd1,
      ST_WAIT = 2'd2,
      ST_HOLD = 2'd3
   } state_t;

   localparam logic [1:0]        CMD_READ  = 2'b11;
   localparam logic [1:0]        CMD_NOP   = 2'b00;
   localparam logic [ADDR_W-1:0] ADDR_MASK = ADDR_W'(DEPTH - 1);
   localparam logic [ADDR_W-1:0] MAX_LEN   = ADDR_W'(DEPTH);

   state_t            state;
   logic [ADDR_W-1:0] base_r;
   logic [ADDR_W-1:0] len_r;
   logic [ADDR_W-1:0] count;
   logic [ADDR_W-1:0] next_count;
   logic              last_byte;
`ifdef REFRESH_LOOP_EN
   logic              stop_pend;
`endif

   // Memory address of the n-th byte of a run, wrapped into the memory depth.
   function automatic logic [ADDR_W-1:0] wrap_addr(input logic [ADDR_W-1:0] b,
                                                   input logic [ADDR_W-1:0] n);
      return (b + n) & ADDR_MASK;
   endfunction

   function automatic logic [ADDR_W-1:0] clamp_len(input logic [ADDR_W-1:0] l);
      return (l > MAX_LEN) ? MAX_LEN : l;
   endfunction

   // Position bookkeeping for the byte currently held downstream.
   always_comb begin
      next_count = count + ADDR_W'(1);
      if (next_count == len_r) begin
         last_byte = 1'b1;
      end else begin
         last_byte = 1'b0;
      end
   end

   // Run sequencer; every output is a register so the memory sees clean commands.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state         <= ST_IDLE;
         base_r        <= '0;
         len_r         <= '0;
         count         <= '0;
         busy          <= 1'b0;
         done          <= 1'b0;
         bus.mem_rw    <= CMD_NOP;
         bus.mem_addr  <= '0;
         bus.out_data  <= '0;
         bus.out_index <= '0;
         bus.out_valid <= 1'b0;
`ifdef REFRESH_LOOP_EN
         stop_pend     <= 1'b0;
`endif
      end else begin
         done <= 1'b0;
`ifdef REFRESH_LOOP_EN
         if (stop) begin
            stop_pend <= 1'b1;
         end
`endif
         case (state)
            ST_IDLE: begin
               if (start) begin
                  base_r <= base_addr & ADDR_MASK;
                  len_r  <= clamp_len(len);
                  count  <= '0;
`ifdef REFRESH_LOOP_EN
                  stop_pend <= stop;
`endif
                  if (len == '0) begin
                     done <= 1'b1;
                  end else begin
                     state        <= ST_REQ;
                     busy         <= 1'b1;
                     bus.mem_rw   <= CMD_READ;
                     bus.mem_addr <= base_addr & ADDR_MASK;
                  end
               end
            end
            ST_REQ: begin
               bus.mem_rw <= CMD_NOP;
               state      <= ST_WAIT;
            end
            ST_WAIT: begin
               // Memory registered its answer at the end of REQ; it is valid exactly now.
               bus.out_data  <= bus.mem_save;
               bus.out_index <= count;
               bus.out_valid <= 1'b1;
               state         <= ST_HOLD;
            end
            ST_HOLD: begin
               if (bus.out_ready) begin
                  bus.out_valid <= 1'b0;
                  if (last_byte) begin
                     done <= 1'b1;
`ifdef REFRESH_LOOP_EN
                     if (stop_pend || stop) begin
                        state     <= ST_IDLE;
                        busy      <= 1'b0;
                        count     <= next_count;
                        stop_pend <= 1'b0;
                     end else begin
                        state        <= ST_REQ;
                        count        <= '0;
                        bus.mem_rw   <= CMD_READ;
                        bus.mem_addr <= base_r;
                     end
`else
                     state <= ST_IDLE;
                     busy  <= 1'b0;
                     count <= next_count;
`endif
                  end else begin
                     count        <= next_count;
                     state        <= ST_REQ;
                     bus.mem_rw   <= CMD_READ;
                     bus.mem_addr <= wrap_addr(base_r, next_count);
                  end
               end
            end
            default: begin
               state         <= ST_IDLE;
               busy          <= 1'b0;
               bus.mem_rw    <= CMD_NOP;
               bus.out_valid <= 1'b0;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_lcd_mem_reader.sv
// Randomized scoreboard bench for lcd_mem_reader against a bench-side 16x8 memory model.
module tb_lcd_mem_reader;
   localparam int DEPTH  = 16;
   localparam int ADDR_W = 5;
   localparam int DATA_W = 8;

   typedef struct {
      logic [7:0] data;
      logic [4:0] idx;
   } beat_t;

   logic       clk = 1'b0;
   logic       rst = 1'b1;
   logic       start = 1'b0;
   logic [4:0] base_addr = 5'd0;
   logic [4:0] len = 5'd0;
   logic       busy;
   logic       done;
`ifdef REFRESH_LOOP_EN
   logic       stop = 1'b1;
`endif

   logic [7:0] mem [DEPTH];
   beat_t      exp_q[$];
   logic [4:0] addr_q[$];
   int         n_checks = 0;
   int         n_fail = 0;
   int         ready_mode = 1;

   logic       hold_seen = 1'b0;
   logic [7:0] hold_data;
   logic [4:0] hold_idx;

   lcd_mem_reader_if #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) bus ();

   lcd_mem_reader #(.DEPTH(DEPTH), .ADDR_W(ADDR_W), .DATA_W(DATA_W)) dut (
      .clk(clk),
      .rst(rst),
      .start(start),
      .base_addr(base_addr),
      .len(len),
`ifdef REFRESH_LOOP_EN
      .stop(stop),
`endif
      .busy(busy),
      .done(done),
      .bus(bus)
   );

   always #5 clk = ~clk;

   // Register-file memory: answers a read at the request edge, zeroes save when idle.
   always @(posedge clk) begin
      if (bus.mem_rw == 2'b11) bus.mem_save <= mem[bus.mem_addr[3:0]];
      else                     bus.mem_save <= 8'h00;
   end

   // Downstream ready: 0 = stalled, 1 = always ready, otherwise random.
   initial begin
      bus.out_ready = 1'b0;
      forever begin
         @(posedge clk);
         #1;
         case (ready_mode)
            0:       bus.out_ready = 1'b0;
            1:       bus.out_ready = 1'b1;
            default: bus.out_ready = 1'($urandom_range(0, 1));
         endcase
      end
   end

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
      end
   endtask

   // Reference: a run is min(len,DEPTH) consecutive addresses from base mod DEPTH.
   task automatic push_run(input int b, input int l);
      int n;
      int a;
      n = (l > DEPTH) ? DEPTH : l;
      for (int i = 0; i < n; i++) begin
         a = (b + i) % DEPTH;
         addr_q.push_back(5'(a));
         exp_q.push_back('{data: mem[a], idx: 5'(i)});
      end
   endtask

   task automatic start_run(input int b, input int l);
      @(posedge clk);
      #1;
      start = 1'b1;
      base_addr = 5'(b);
      len = 5'(l);
      @(posedge clk);
      #1;
      start = 1'b0;
   endtask

   task automatic wait_done(input int exp_cyc, input bit poke);
      int n;
      bit seen;
      n = 0;
      seen = 1'b0;
      while (n < 2000 && !seen) begin
         @(negedge clk);
         n++;
         if (poke && n == 4) begin
            start = 1'b1;
            base_addr = 5'd9;
            len = 5'd5;
         end
         if (poke && n == 5) start = 1'b0;
         if (done) seen = 1'b1;
      end
      chk("done_seen", 32'(seen), 32'd1);
      if (exp_cyc >= 0) chk("done_latency", n, exp_cyc);
      chk("busy_after_done", 32'(busy), 32'd0);
      chk("data_queue_drained", exp_q.size(), 32'd0);
      chk("addr_queue_drained", addr_q.size(), 32'd0);
      @(negedge clk);
      chk("done_one_pulse", 32'(done), 32'd0);
   endtask

   task automatic chk_idle_outputs(input string tag);
      chk({tag, "_mem_rw"}, 32'(bus.mem_rw), 32'd0);
      chk({tag, "_mem_addr"}, 32'(bus.mem_addr), 32'd0);
      chk({tag, "_out_data"}, 32'(bus.out_data), 32'd0);
      chk({tag, "_out_index"}, 32'(bus.out_index), 32'd0);
      chk({tag, "_out_valid"}, 32'(bus.out_valid), 32'd0);
      chk({tag, "_busy"}, 32'(busy), 32'd0);
      chk({tag, "_done"}, 32'(done), 32'd0);
   endtask

   // Monitor: reads and delivered bytes are popped against the scoreboard queues.
   initial begin
      beat_t e;
      logic [4:0] ea;
      forever begin
         @(negedge clk);
         if (!rst) begin
            if (bus.mem_rw == 2'b10) begin
               n_checks++;
               n_fail++;
               $display("FAIL mem_write: reader issued a write at addr 0x%0h", bus.mem_addr);
            end
            if (bus.mem_rw == 2'b11) begin
               if (addr_q.size() == 0) begin
                  n_checks++;
                  n_fail++;
                  $display("FAIL unexpected_read: addr 0x%0h with no read expected", bus.mem_addr);
               end else begin
                  ea = addr_q.pop_front();
                  chk("mem_addr", 32'(bus.mem_addr), 32'(ea));
               end
            end
            if (hold_seen) begin
               chk("hold_valid", 32'(bus.out_valid), 32'd1);
               chk("hold_data", 32'(bus.out_data), 32'(hold_data));
               chk("hold_index", 32'(bus.out_index), 32'(hold_idx));
            end
            hold_seen = 1'b0;
            if (bus.out_valid) begin
               chk("rw_idle_while_valid", 32'(bus.mem_rw), 32'd0);
               if (bus.out_ready) begin
                  if (exp_q.size() == 0) begin
                     n_checks++;
                     n_fail++;
                     $display("FAIL unexpected_byte: data 0x%0h index %0d", bus.out_data, bus.out_index);
                  end else begin
                     e = exp_q.pop_front();
                     chk("out_data", 32'(bus.out_data), 32'(e.data));
                     chk("out_index", 32'(bus.out_index), 32'(e.idx));
                  end
               end else begin
                  hold_seen = 1'b1;
                  hold_data = bus.out_data;
                  hold_idx  = bus.out_index;
               end
            end
         end else begin
            hold_seen = 1'b0;
         end
      end
   end

   initial begin
      int b;
      int l;
      int exp_cyc;
      for (int i = 0; i < DEPTH; i++) mem[i] = 8'($urandom);

      repeat (3) @(posedge clk);
      @(negedge clk);
      chk_idle_outputs("reset");
      rst = 1'b0;
      ready_mode = 1;

      // Basic three-byte run.
      mem[3] = 8'h41; mem[4] = 8'h42; mem[5] = 8'h43;
      push_run(3, 3);
      start_run(3, 3);
      wait_done(10, 1'b0);

      // Wrap past the top of memory.
      mem[15] = 8'hAA; mem[0] = 8'hBB;
      push_run(15, 2);
      start_run(15, 2);
      wait_done(7, 1'b0);

      push_run(14, 4);
      start_run(14, 4);
      wait_done(13, 1'b0);

      // Zero length: no access, done one cycle after start.
      start_run(6, 0);
      wait_done(1, 1'b0);

      // Start while busy must not disturb the run.
      push_run(2, 4);
      start_run(2, 4);
      wait_done(13, 1'b1);

      // Backpressure: byte must sit still with no new read.
      ready_mode = 0;
      push_run(7, 2);
      start_run(7, 2);
      repeat (8) @(negedge clk);
      chk("bp_valid", 32'(bus.out_valid), 32'd1);
      chk("bp_index", 32'(bus.out_index), 32'd0);
      ready_mode = 1;
      @(posedge clk);
      #2;
      @(negedge clk);
      @(negedge clk);
      chk("req_after_accept", 32'(bus.mem_rw), 32'd3);
      wait_done(-1, 1'b0);

      // Reset during WAIT abandons the run.
      addr_q.push_back(5'd2);
      start_run(2, 3);
      @(negedge clk);
      @(negedge clk);
      rst = 1'b1;
      #1;
      chk_idle_outputs("midrun_reset");
      @(negedge clk);
      rst = 1'b0;
      repeat (3) begin
         @(negedge clk);
         chk("no_done_after_reset", 32'(done), 32'd0);
      end
      chk("reset_addr_queue", addr_q.size(), 32'd0);
      push_run(2, 3);
      start_run(2, 3);
      wait_done(10, 1'b0);

      // Randomized runs, including over-long and out-of-range requests.
      for (int k = 0; k < 12; k++) begin
         b = $urandom_range(0, 31);
         l = $urandom_range(0, 20);
         if ($urandom_range(0, 1) == 0) begin
            ready_mode = 1;
            exp_cyc = 3 * ((l > DEPTH) ? DEPTH : l) + 1;
         end else begin
            ready_mode = 2;
            exp_cyc = -1;
         end
         push_run(b, l);
         start_run(b, l);
         wait_done(exp_cyc, 1'b0);
      end
      ready_mode = 1;

`ifdef REFRESH_LOOP_EN
      begin
         int n;
         int dones;
         @(negedge clk);
         stop = 1'b0;
         push_run(0, 2);
         push_run(0, 2);
         start_run(0, 2);
         n = 0;
         dones = 0;
         while (n < 200 && (n < 2 || busy)) begin
            @(negedge clk);
            n++;
            if (n == 9) stop = 1'b1;
            if (n == 10) stop = 1'b0;
            if (done) dones++;
         end
         chk("refresh_done_count", dones, 32'd2);
         chk("refresh_busy_low", 32'(busy), 32'd0);
         chk("refresh_queue_drained", exp_q.size(), 32'd0);
         stop = 1'b1;
      end
`endif

      repeat (4) @(negedge clk);
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end
endmodule
